// File: rtl/synth_pkg.sv
// Shared types and constants for the synth sample path.
package synth_pkg;

    localparam int unsigned SAMPLE_BUS_WIDTH = 12;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_REL  = 2'd2
    } hs_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned sample_rate);
        return clk_freq / sample_rate;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/synth_sample_buffer_if.sv
// Sample stream in from the truncator and req/ack handshake out to the PWM CDC.
interface synth_sample_buffer_if #(
    parameter int unsigned BUS_WIDTH = synth_pkg::SAMPLE_BUS_WIDTH
);
    logic [BUS_WIDTH-1:0] sample_in;
    logic                 sample_in_valid;
    logic                 sample_in_ready;
    logic [BUS_WIDTH-1:0] duty_cycle;
    logic                 req;
    logic                 ack;

    modport master (
        output sample_in, sample_in_valid, ack,
        input  sample_in_ready, duty_cycle, req
    );

    modport slave (
        input  sample_in, sample_in_valid, ack,
        output sample_in_ready, duty_cycle, req
    );
endinterface

// File: rtl/sample_fifo.sv
// Synchronous FIFO with registered occupancy; flush empties it and drops a same-cycle push.
module sample_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // A pop in the flush cycle has already read its data; flush just resets the pointers.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/synth_sample_buffer.sv
// Elastic sample buffer: FIFO in, one sample per rate tick out over a four-phase req/ack.
module synth_sample_buffer import synth_pkg::*; #(
    parameter int unsigned CPU_CLOCK_FREQ = 125_000_000,
    parameter int unsigned SAMPLE_RATE    = 30_000,
    parameter int unsigned BUS_WIDTH      = SAMPLE_BUS_WIDTH,
    parameter int unsigned DEPTH          = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    synth_sample_buffer_if.slave        bus,
    output logic [15:0]                 underflow_count,
    output logic [15:0]                 missed_tick_count
);
    localparam int unsigned DIV   = calc_div(CPU_CLOCK_FREQ, SAMPLE_RATE);
    localparam int unsigned TickW = $clog2(DIV);

    logic [TickW-1:0]     tick_cnt_q;
    logic                 tick;
    logic                 ack_meta_q, ack_s_q;
    hs_state_t            state_q, state_d;
    logic                 req_q, req_d;
    logic [BUS_WIDTH-1:0] duty_q, duty_d;
    logic [15:0]          uf_q, uf_d, missed_q, missed_d;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [BUS_WIDTH-1:0] fifo_head;

    assign tick = (tick_cnt_q == TickW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= bus.ack;
            ack_s_q    <= ack_meta_q;
        end
    end

    sample_fifo #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (bus.sample_in_valid),
        .push_data (bus.sample_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        duty_d   = duty_q;
        uf_d     = uf_q;
        missed_d = missed_q;
        fifo_pop = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (tick) begin
                    // Empty FIFO repeats the previous sample so the DAC never glitches.
                    fifo_pop = 1'b1;
                    if (fifo_empty) uf_d = sat_inc16(uf_q);
                    else            duty_d = fifo_head;
                    req_d   = 1'b1;
                    state_d = HS_REQ;
                end
            end
            HS_REQ: begin
                if (tick) missed_d = sat_inc16(missed_q);
                if (ack_s_q) begin
                    req_d   = 1'b0;
                    state_d = HS_REL;
                end
            end
            HS_REL: begin
                if (tick) missed_d = sat_inc16(missed_q);
                if (!ack_s_q) state_d = HS_IDLE;
            end
            default: state_d = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HS_IDLE;
            req_q    <= 1'b0;
            duty_q   <= '0;
            uf_q     <= '0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            duty_q   <= duty_d;
            uf_q     <= uf_d;
            missed_q <= missed_d;
        end
    end

    assign bus.sample_in_ready = !fifo_full;
    assign bus.duty_cycle      = duty_q;
    assign bus.req             = req_q;
    assign underflow_count     = uf_q;
    assign missed_tick_count   = missed_q;

endmodule

// File: tb/tb_synth_sample_buffer.sv
// Scoreboard bench for synth_sample_buffer with a behavioural CDC ack responder.
module tb_synth_sample_buffer;
    localparam int unsigned W = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] uf_cnt, missed_cnt;

    synth_sample_buffer_if #(.BUS_WIDTH(W)) bus ();

    synth_sample_buffer #(
        .CPU_CLOCK_FREQ (100),
        .SAMPLE_RATE    (10),
        .BUS_WIDTH      (W),
        .DEPTH          (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .bus               (bus),
        .underflow_count   (uf_cnt),
        .missed_tick_count (missed_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // CDC ack responder: raise ack ack_delay cycles after req, hold it at least ack_hold cycles.
    int   ack_delay = 2;
    int   ack_hold  = 0;
    int   a_st = 0;
    int   a_cnt = 0;
    logic ack_rst;

    always @(posedge clk) begin
        ack_rst = rst;
        #1;
        if (ack_rst) begin
            bus.ack = 1'b0;
            a_st    = 0;
        end else begin
            case (a_st)
                0: if (bus.req) begin
                    if (ack_delay == 0) begin
                        bus.ack = 1'b1;
                        a_cnt   = 0;
                        a_st    = 2;
                    end else begin
                        a_cnt = ack_delay;
                        a_st  = 1;
                    end
                end
                1: begin
                    a_cnt--;
                    if (a_cnt == 0) begin
                        bus.ack = 1'b1;
                        a_st    = 2;
                    end
                end
                default: begin
                    a_cnt++;
                    if (!bus.req && a_cnt >= ack_hold) begin
                        bus.ack = 1'b0;
                        a_st    = 0;
                    end
                end
            endcase
        end
    end

    // Scoreboard: expected FIFO contents; each req rise pops one or counts an underflow.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_duty = '0;
    int           exp_uf = 0;
    int           rise_cnt = 0;
    logic         req_prev = 1'b0;
    logic         pend_v = 1'b0;
    logic [W-1:0] pend_d = '0;
    logic         flush_p = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_duty = '0;
            exp_uf    = 0;
            rise_cnt  = 0;
            req_prev  = 1'b0;
            pend_v    = 1'b0;
            flush_p   = 1'b0;
        end else begin
            if (bus.req && !req_prev) begin
                rise_cnt++;
                if (exp_q.size() > 0) last_duty = exp_q.pop_front();
                else                  exp_uf++;
                check_eq("duty_at_req", 32'(bus.duty_cycle), 32'(last_duty));
                check_eq("underflow_at_req", 32'(uf_cnt), exp_uf);
            end
            if (flush_p)     exp_q.delete();
            else if (pend_v) exp_q.push_back(pend_d);
            req_prev = bus.req;
            pend_v   = bus.sample_in_valid && bus.sample_in_ready && !flush;
            pend_d   = bus.sample_in;
            flush_p  = flush;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] d);
        bus.sample_in       = d;
        bus.sample_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.sample_in_valid = 1'b0;
    endtask

    task automatic wait_rises(input int n, input int budget);
        int b = budget;
        while (rise_cnt < n && b > 0) begin
            @(posedge clk);
            #1;
            b--;
        end
        check_eq("req_rises", rise_cnt, n);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_req"}, 32'(bus.req), 0);
        check_eq({tag, "_duty"}, 32'(bus.duty_cycle), 0);
        check_eq({tag, "_ready"}, 32'(bus.sample_in_ready), 1);
        check_eq({tag, "_underflow"}, 32'(uf_cnt), 0);
        check_eq({tag, "_missed"}, 32'(missed_cnt), 0);
    endtask

    initial begin
        bus.sample_in       = '0;
        bus.sample_in_valid = 1'b0;

        do_reset();
        check_reset_state("reset");

        // Basic transfer
        push(12'h123);
        push(12'h456);
        idle(24);
        check_eq("basic_req_pulses", rise_cnt, 2);
        check_eq("basic_duty", 32'(bus.duty_cycle), 32'h456);
        check_eq("basic_underflow", 32'(uf_cnt), 0);

        // Full: fifth sample is held off
        do_reset();
        bus.sample_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.sample_in = 12'(12'h200 + i);
            check_eq("full_ready", 32'(bus.sample_in_ready), (i < 4) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        check_eq("full_ready_held", 32'(bus.sample_in_ready), 0);
        idle(1);
        bus.sample_in_valid = 1'b0;
        wait_rises(1, 20);
        check_eq("full_ready_after_pop", 32'(bus.sample_in_ready), 1);
        wait_rises(4, 40);
        check_eq("full_no_underflow", 32'(uf_cnt), 0);
        wait_rises(5, 20);
        check_eq("full_fifth_underflows", 32'(uf_cnt), 1);

        // Underflow repeats the last sample
        do_reset();
        push(12'h0AB);
        wait_rises(2, 40);
        check_eq("uf_duty_repeat", 32'(bus.duty_cycle), 32'h0AB);
        check_eq("uf_count", 32'(uf_cnt), 1);

        // Slow ack: one tick lands in the busy handshake
        do_reset();
        ack_delay = 0;
        ack_hold  = 15;
        push(12'h111);
        push(12'h222);
        idle(25);
        check_eq("slow_missed", 32'(missed_cnt), 1);
        check_eq("slow_rises", rise_cnt, 1);
        wait_rises(2, 30);
        check_eq("slow_duty", 32'(bus.duty_cycle), 32'h222);
        check_eq("slow_missed_after", 32'(missed_cnt), 1);
        check_eq("slow_underflow", 32'(uf_cnt), 0);

        // Flush with three queued and a simultaneous push
        do_reset();
        ack_delay = 2;
        ack_hold  = 0;
        push(12'h321);
        wait_rises(1, 20);
        push(12'h0A1);
        push(12'h0A2);
        push(12'h0A3);
        bus.sample_in       = 12'h999;
        bus.sample_in_valid = 1'b1;
        flush               = 1'b1;
        @(posedge clk);
        #1;
        flush               = 1'b0;
        bus.sample_in_valid = 1'b0;
        wait_rises(2, 20);
        check_eq("flush_duty_repeat", 32'(bus.duty_cycle), 32'h321);
        check_eq("flush_underflow", 32'(uf_cnt), 1);
        wait_rises(3, 20);
        check_eq("flush_push_dropped", 32'(uf_cnt), 2);

        // Reset in the middle of a handshake
        push(12'h5A5);
        wait_rises(4, 20);
        check_eq("pre_rst_req", 32'(bus.req), 1);
        do_reset();
        check_reset_state("mid_rst");
        push(12'h777);
        wait_rises(1, 20);
        check_eq("post_rst_duty", 32'(bus.duty_cycle), 32'h777);
        check_eq("post_rst_underflow", 32'(uf_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
